dds_sweep_ctrl: RTL
===================

# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase-accumulator core. It latches a sweep configuration on `start`, then drives the core's frequency control word `K` and phase offset `P` through a stepped linear ramp. Each frequency is held for a programmable dwell time. Status is reported via `busy`, a per-step `step_tick` and a completion `done` pulse. It sits between the register/control logic and the DDS wave core, whose `K`/`P` inputs it feeds directly.

## Interface
Parameters:
- `KW`, 32, frequency control word width (matches DDS accumulator).
- `PW`, 11, phase offset width.
- `CW`, 16, width of step-count and dwell counters.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `stop`  in  1  abort sweep; sampled in any state.
- `f_start`  in  KW  first frequency word.
- `f_step`  in  KW  signed (two's complement) increment per step.
- `n_steps`  in  CW  number of frequencies in one ramp; 0 treated as 1.
- `dwell`  in  CW  hold time per frequency, in cycles minus one.
- `p_off`  in  PW  phase offset applied for the whole sweep.
- `cont`  in  1  1 = repeat ramp until `stop`; 0 = single ramp.
- `bidir`  in  1  triangle sweep select (see Configuration).
- `K`  out  KW  frequency word to DDS core.
- `P`  out  PW  phase offset to DDS core.
- `busy`  out  1  high from first sweep cycle until return to IDLE.
- `step_tick`  out  1  one-cycle pulse each time `K` takes a new value during a sweep.
- `done`  out  1  one-cycle pulse on normal completion of a single ramp.

## Operation
- FSM states are IDLE, RUN and FINISH.
- **Reset:** state = IDLE. `K`=0, `P`=0, `busy`=0, `step_tick`=0, `done`=0. All counters are 0.
- **IDLE:**
  - `start`=1 and `stop`=0 latches `f_start`, `f_step`, `n_steps`, `dwell`, `p_off`, `cont` and `bidir` into shadow registers, then goes to RUN.
  - Input changes after the latch have no effect until the next start.
  - If `start` and `stop` are both high in IDLE, `stop` wins and the FSM stays in IDLE.
- **RUN:**
  - Ramp index i = 0..N-1 (N = max(`n_steps`,1)) gives `K` = `f_start` + i·`f_step` mod 2^KW. Wrap-around is silent, with no saturation.
  - The next `K` is computed by accumulating `f_step` onto `K`, not by multiplying.
  - Each value is held `dwell`+1 cycles by a dwell counter. The step counter counts values issued.
  - After the dwell of index N-1:
    - `cont`=0: go to FINISH.
    - `cont`=1: reload `K`=`f_start` and continue with no gap cycle.
- **FINISH:** for one cycle, `done`=1 and `busy` is still 1. Next cycle: IDLE, `busy`=0.
- **`stop` in RUN or FINISH:** next cycle is IDLE with `busy`=0, no `done` pulse, and no further `step_tick`. `stop` in FINISH suppresses `done` only if sampled in the same cycle as entering FINISH; otherwise the pulse already completed.
- **Outputs in IDLE:** `K` and `P` hold their last values, so the DDS keeps running at the final or aborted frequency.
- **`start` while busy:** ignored.

## Timing
- **Start latency:** `start` sampled at edge n gives `K`=`f_start`, `P`=`p_off`, `busy`=1 and `step_tick`=1 at edge n+1.
- **Step cadence:** `K` changes, with `step_tick`=1, every `dwell`+1 cycles.
- **Completion:** `done` is asserted at edge (n+1)+N·(`dwell`+1) for `cont`=0. `busy` falls one cycle later.
  - Total `busy` high time = N·(`dwell`+1)+1 cycles.
- **Stop latency:** `stop` at edge m gives `busy`=0 at edge m+1.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.

## Configuration
- **`DDS_SWEEP_BIDIR_EN` defined:**
  - With latched `bidir`=1, after index N-1 the ramp reverses by subtracting `f_step` through indices N-2..0. This gives 2N-1 values per pass.
  - `done` follows the dwell of the returning index 0.
  - `cont`=1 repeats as a triangle without duplicating endpoints: …,1,0,1,2,…,N-1,N-2,…
  - N=1 behaves as unidirectional.
- **Macro not defined:**
  - The `bidir` port is still present but ignored.
  - No direction logic is built; behaviour is identical to `bidir`=0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-sweep with `K`=0x1000 → `K`=0, `P`=0, `busy`=0, `done`=0 immediately (asynchronous); FSM stays in IDLE after release.
- **Single ramp:** `f_start`=0x100, `f_step`=0x10, `n_steps`=4, `dwell`=2, `p_off`=0x055 → `K` sequence 0x100, 0x110, 0x120, 0x130, each held 3 cycles, `P`=0x055; `done` 13 cycles after `start`; `busy` high 13 cycles.
- **Wrap:** `f_start`=0xFFFF_FFF0, `f_step`=0x20, `n_steps`=2, `dwell`=0 → `K`=0xFFFF_FFF0 then 0x0000_0010; `done` on the third cycle.
- **Continuous + stop:** `cont`=1, `n_steps`=3, `f_step`=1, `f_start`=5, `dwell`=0 → `K` 5,6,7,5,6,… with no gap; `stop` at any cycle → `busy`=0 next cycle, no `done`, `K` frozen.
- **Edge inputs:** `n_steps`=0 → exactly one frequency, `done` after `dwell`+1 cycles. Simultaneous `start`+`stop` in IDLE → no sweep. `start` during RUN → ignored.
- **Bidirectional (`DDS_SWEEP_BIDIR_EN` defined):** `bidir`=1, `n_steps`=3, `f_start`=0, `f_step`=4, `dwell`=0 → `K` 0,4,8,4,0 then `done`. With `cont`=1 → 0,4,8,4,0,4,8,…

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency-sweep sequencer feeding K/P of the DDS phase-accumulator core.
// Optional triangle (up/down) sweep is built only when DDS_SWEEP_BIDIR_EN is defined.
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [KW-1:0] f_start,
  input  logic [KW-1:0] f_step,
  input  logic [CW-1:0] n_steps,
  input  logic [CW-1:0] dwell,
  input  logic [PW-1:0] p_off,
  input  logic          cont,
  input  logic          bidir,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          busy,
  output logic          step_tick,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state_q;
  logic [KW-1:0] f_start_q;
  logic [KW-1:0] f_step_q;
  logic [CW-1:0] last_q;
  logic [CW-1:0] dwell_q;
  logic          cont_q;
  logic [CW-1:0] dwell_cnt_q;
  logic [CW-1:0] idx_q;
  logic [KW-1:0] k_q;
  logic [PW-1:0] p_q;
  logic          busy_q;
  logic          tick_q;
  logic          done_q;

  logic [KW-1:0] k_d;
  logic [CW-1:0] idx_d;
  logic          ramp_end;

`ifdef DDS_SWEEP_BIDIR_EN
  logic          bidir_q;
  logic          down_q;
  logic          down_d;
`else
  logic          unused_bidir;
  assign unused_bidir = bidir;
`endif

  // Next frequency/index once the current dwell expires; ramp_end marks the end of a pass.
  always_comb begin
    k_d      = k_q + f_step_q;
    idx_d    = idx_q + CW'(1);
    ramp_end = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    down_d   = down_q;
    if (down_q) begin
      k_d   = k_q - f_step_q;
      idx_d = idx_q - CW'(1);
      if (idx_q == '0) begin
        ramp_end = 1'b1;
        down_d   = 1'b0;
        k_d      = k_q + f_step_q;
        idx_d    = CW'(1);
      end
    end else if (idx_q == last_q) begin
      if (bidir_q && (last_q != '0)) begin
        down_d = 1'b1;
        k_d    = k_q - f_step_q;
        idx_d  = idx_q - CW'(1);
      end else begin
        ramp_end = 1'b1;
        k_d      = f_start_q;
        idx_d    = '0;
      end
    end
`else
    if (idx_q == last_q) begin
      ramp_end = 1'b1;
      k_d      = f_start_q;
      idx_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f_start_q   <= '0;
      f_step_q    <= '0;
      last_q      <= '0;
      dwell_q     <= '0;
      cont_q      <= 1'b0;
      dwell_cnt_q <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      p_q         <= '0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      bidir_q     <= 1'b0;
      down_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tick_q <= 1'b0;
          done_q <= 1'b0;
          if (start && !stop) begin
            f_start_q   <= f_start;
            f_step_q    <= f_step;
            last_q      <= (n_steps == '0) ? '0 : n_steps - CW'(1);
            dwell_q     <= dwell;
            cont_q      <= cont;
            dwell_cnt_q <= '0;
            idx_q       <= '0;
            k_q         <= f_start;
            p_q         <= p_off;
            busy_q      <= 1'b1;
            tick_q      <= 1'b1;
            state_q     <= RUN;
`ifdef DDS_SWEEP_BIDIR_EN
            bidir_q     <= bidir;
            down_q      <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
          end else if (dwell_cnt_q != dwell_q) begin
            dwell_cnt_q <= dwell_cnt_q + CW'(1);
            tick_q      <= 1'b0;
          end else begin
            dwell_cnt_q <= '0;
            if (ramp_end && !cont_q) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              tick_q  <= 1'b0;
            end else begin
              k_q    <= k_d;
              idx_q  <= idx_d;
              tick_q <= 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
              down_q <= down_d;
`endif
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          tick_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          tick_q  <= 1'b0;
        end
      endcase
    end
  end

  assign K         = k_q;
  assign P         = p_q;
  assign busy      = busy_q;
  assign step_tick = tick_q;
  assign done      = done_q;

endmodule
